// File: rtl/mem_access_ctrl_pkg.sv
// Shared CPU definitions for the memory-access stage: widths, FSM states and
// the memory/writeback field bundle.
package mem_access_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mac_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   read_data;
    logic [XLEN-1:0]   alu_result;
    logic [REG_AW-1:0] write_reg_addr;
    logic              mem_reg;
    logic              reg_write;
  } mw_fields_t;

endpackage

// File: rtl/mem_access_ctrl_mw_reg.sv
// Memory/writeback pipeline register bank: holds when load is low, clears
// synchronously on clr.
module mw_pipeline_register
  import mem_access_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  mw_fields_t d,
  output mw_fields_t q
);

  mw_fields_t fields_q;
  mw_fields_t fields_d;

  always_comb begin
    fields_d = fields_q;
    if (load) fields_d = d;
  end

  always_ff @(posedge clk) begin
    if (clr) fields_q <= '0;
    else     fields_q <= fields_d;
  end

  assign q = fields_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues data-memory accesses, stalls the pipeline
// while waiting, and flags misaligned/illegal ops and bus timeouts.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [REG_AW-1:0] write_reg_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_reg,
  input  logic              reg_write,
  input  logic [XLEN-1:0]   mem_write_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              stall,
  output logic [XLEN-1:0]   mw_read_data,
  output logic [XLEN-1:0]   mw_alu_result,
  output logic [REG_AW-1:0] mw_write_reg_addr,
  output logic              mw_mem_reg,
  output logic              mw_reg_write,
  output logic              align_fault,
  output logic              bus_error
);

  mac_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             align_fault_q, align_fault_d;
  logic             bus_error_q, bus_error_d;
  logic             mw_load;
  mw_fields_t       mw_d, mw_q;
  logic             mem_op, illegal_op, misaligned;

  assign mem_op     = mem_read ^ mem_write;
  assign illegal_op = mem_read & mem_write;
  assign misaligned = |alu_result[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      align_fault_q <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      align_fault_q <= align_fault_d;
      bus_error_q   <= bus_error_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    align_fault_d    = 1'b0;
    bus_error_d      = 1'b0;
    mw_load          = 1'b0;
    stall            = 1'b0;
    dmem_req         = 1'b0;
    dmem_we          = 1'b0;
    dmem_addr        = '0;
    dmem_wdata       = '0;
    mw_d.read_data      = '0;
    mw_d.alu_result     = alu_result;
    mw_d.write_reg_addr = write_reg_addr;
    mw_d.mem_reg        = mem_reg;
    mw_d.reg_write      = reg_write;

    case (state_q)
      IDLE: begin
        if (illegal_op || (mem_op && misaligned)) begin
          mw_load        = 1'b1;
          mw_d.reg_write = 1'b0;
          align_fault_d  = 1'b1;
        end else if (mem_op) begin
          stall   = 1'b1;
          state_d = ACCESS;
          cnt_d   = '0;
        end else begin
          mw_load = 1'b1;
        end
      end
      ACCESS: begin
        dmem_req   = 1'b1;
        dmem_we    = mem_write;
        dmem_addr  = alu_result;
        dmem_wdata = mem_write_data;
        if (dmem_ready) begin
          mw_load = 1'b1;
          if (mem_read) mw_d.read_data = dmem_rdata;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Abort retires the op (no stall) with its register write suppressed.
          mw_load        = 1'b1;
          mw_d.reg_write = 1'b0;
          bus_error_d    = 1'b1;
          state_d        = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) stall = 1'b0;
  end

  mw_pipeline_register u_mw_reg (
    .clk  (clk),
    .clr  (rst),
    .load (mw_load),
    .d    (mw_d),
    .q    (mw_q)
  );

  assign mw_read_data      = mw_q.read_data;
  assign mw_alu_result     = mw_q.alu_result;
  assign mw_write_reg_addr = mw_q.write_reg_addr;
  assign mw_mem_reg        = mw_q.mem_reg;
  assign mw_reg_write      = mw_q.reg_write;
  assign align_fault       = align_fault_q;
  assign bus_error         = bus_error_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: single-cycle vector table plus
// hand-written multi-cycle sequences, checked through an expected-result queue.
module tb_mem_access_ctrl;

  logic        clk, rst;
  logic [31:0] alu_result, mem_write_data, dmem_rdata, dmem_addr, dmem_wdata;
  logic [31:0] mw_read_data, mw_alu_result;
  logic [4:0]  write_reg_addr, mw_write_reg_addr;
  logic        mem_read, mem_write, mem_reg, reg_write, dmem_ready;
  logic        dmem_req, dmem_we, stall, mw_mem_reg, mw_reg_write;
  logic        align_fault, bus_error;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .alu_result        (alu_result),
    .write_reg_addr    (write_reg_addr),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_reg           (mem_reg),
    .reg_write         (reg_write),
    .mem_write_data    (mem_write_data),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_ready        (dmem_ready),
    .dmem_rdata        (dmem_rdata),
    .stall             (stall),
    .mw_read_data      (mw_read_data),
    .mw_alu_result     (mw_alu_result),
    .mw_write_reg_addr (mw_write_reg_addr),
    .mw_mem_reg        (mw_mem_reg),
    .mw_reg_write      (mw_reg_write),
    .align_fault       (align_fault),
    .bus_error         (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        mreg;
    logic        rw;
    logic        af;
    logic        be;
  } exp_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        mr;
    logic        mw;
    logic        mreg;
    logic        rw;
    logic        exp_stall;
    logic        exp_rw;
    logic        exp_af;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];
  int   tests  = 0;
  int   failed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] rdata, input logic [31:0] alu, input logic [4:0] rd,
                      input logic mreg, input logic rw, input logic af, input logic be);
    exp_q.push_back({rdata, alu, rd, mreg, rw, af, be});
  endtask

  task automatic check_mw(input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s: scoreboard empty, got none, expected an entry", nm);
    end else begin
      e = exp_q.pop_front();
      chk({nm, ".rdata"}, mw_read_data, e.rdata);
      chk({nm, ".alu"},   mw_alu_result, e.alu);
      chk({nm, ".rd"},    32'(mw_write_reg_addr), 32'(e.rd));
      chk({nm, ".mreg"},  32'(mw_mem_reg), 32'(e.mreg));
      chk({nm, ".rw"},    32'(mw_reg_write), 32'(e.rw));
      chk({nm, ".af"},    32'(align_fault), 32'(e.af));
      chk({nm, ".be"},    32'(bus_error), 32'(e.be));
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ".rdata"}, mw_read_data, 32'h0);
    chk({nm, ".alu"},   mw_alu_result, 32'h0);
    chk({nm, ".rd"},    32'(mw_write_reg_addr), 32'h0);
    chk({nm, ".mreg"},  32'(mw_mem_reg), 32'h0);
    chk({nm, ".rw"},    32'(mw_reg_write), 32'h0);
    chk({nm, ".af"},    32'(align_fault), 32'h0);
    chk({nm, ".be"},    32'(bus_error), 32'h0);
  endtask

  task automatic set_op(input logic [31:0] a, input logic [4:0] rd, input logic mr, input logic mw,
                        input logic mreg, input logic rw, input logic [31:0] wd);
    alu_result     = a;
    write_reg_addr = rd;
    mem_read       = mr;
    mem_write      = mw;
    mem_reg        = mreg;
    reg_write      = rw;
    mem_write_data = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int stall_cnt;
    int req_cnt;

    //            alu           rd  mr  mw  mreg rw  stall rw  af
    vecs[0] = '{32'h0000_0005, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0042, 5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0081, 5'd2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h1234_0000, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0040, 5'd9,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_0043, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset with an aligned read presented: no stall, everything cleared
    rst        = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    set_op(32'h40, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    tick();
    chk("rst.stall", 32'(stall), 32'h0);
    chk("rst.req", 32'(dmem_req), 32'h0);
    check_zero("rst");
    tick();
    rst = 1'b0;
    set_op(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // Single-cycle ops with a stray dmem_ready that must be ignored
    dmem_ready = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 7; i++) begin
      set_op(vecs[i].alu, vecs[i].rd, vecs[i].mr, vecs[i].mw, vecs[i].mreg, vecs[i].rw, 32'hA5A5_A5A5);
      #1;
      chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d.req", i), 32'(dmem_req), 32'h0);
      chk($sformatf("vec%0d.addr", i), dmem_addr, 32'h0);
      push(32'h0, vecs[i].alu, vecs[i].rd, vecs[i].mreg, vecs[i].exp_rw, vecs[i].exp_af, 1'b0);
      tick();
      check_mw($sformatf("vec%0d", i));
    end
    dmem_ready = 1'b0;

    // Read 0x40, ready in first access cycle, then back-to-back read 0x44
    set_op(32'h40, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    #1;
    chk("rd40.stall_idle", 32'(stall), 32'h1);
    chk("rd40.req_idle", 32'(dmem_req), 32'h0);
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd40.req", 32'(dmem_req), 32'h1);
    chk("rd40.we", 32'(dmem_we), 32'h0);
    chk("rd40.addr", dmem_addr, 32'h40);
    chk("rd40.stall_acc", 32'(stall), 32'h0);
    push(32'hDEAD_BEEF, 32'h40, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_op(32'h44, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    dmem_ready = 1'b0;
    #1;
    check_mw("rd40");
    chk("rd44.stall_idle", 32'(stall), 32'h1);
    chk("rd44.req_idle", 32'(dmem_req), 32'h0);
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    #1;
    chk("rd44.req", 32'(dmem_req), 32'h1);
    chk("rd44.addr", dmem_addr, 32'h44);
    push(32'hCAFE_F00D, 32'h44, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_op(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    dmem_ready = 1'b0;
    #1;
    check_mw("rd44");
    chk("rd44.req_after", 32'(dmem_req), 32'h0);

    // Write 0x80 with ready delayed three access cycles
    set_op(32'h80, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
    stall_cnt = 0;
    req_cnt   = 0;
    for (int k = 0; k <= 4; k++) begin
      dmem_ready = (k == 4);
      #1;
      if (stall) stall_cnt++;
      if (dmem_req) begin
        req_cnt++;
        chk($sformatf("wr80.addr%0d", k), dmem_addr, 32'h80);
        chk($sformatf("wr80.wdata%0d", k), dmem_wdata, 32'h1234_5678);
        chk($sformatf("wr80.we%0d", k), 32'(dmem_we), 32'h1);
      end
      if (k == 4) push(32'h0, 32'h80, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_op(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    dmem_ready = 1'b0;
    #1;
    check_mw("wr80");
    chk("wr80.stall_cycles", 32'(stall_cnt), 32'd4);
    chk("wr80.req_cycles", 32'(req_cnt), 32'd4);

    // Read with ready held low: abort after four access cycles
    set_op(32'h100, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    #1;
    chk("tmo.stall_idle", 32'(stall), 32'h1);
    tick();
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk($sformatf("tmo.req%0d", k), 32'(dmem_req), 32'h1);
      if (k < 4) chk($sformatf("tmo.stall%0d", k), 32'(stall), 32'h1);
      if (k == 4) push(32'h0, 32'h100, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
    end
    set_op(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check_mw("tmo");
    chk("tmo.req_after", 32'(dmem_req), 32'h0);
    push(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_mw("tmo_clr");

    // Reset in the second access cycle abandons the access
    set_op(32'h200, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    #1;
    chk("rstacc.stall_idle", 32'(stall), 32'h1);
    tick();
    #1;
    chk("rstacc.req1", 32'(dmem_req), 32'h1);
    tick();
    rst = 1'b1;
    #1;
    chk("rstacc.stall_in_rst", 32'(stall), 32'h0);
    tick();
    rst = 1'b0;
    set_op(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h55AA_55AA;
    #1;
    chk("rstacc.req_after", 32'(dmem_req), 32'h0);
    chk("rstacc.stall_after", 32'(stall), 32'h0);
    check_zero("rstacc");
    set_op(32'h77, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    push(32'h0, 32'h77, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_mw("post_rst");
    chk("post_rst.req", 32'(dmem_req), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
